fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one request in flight, one-entry output buffer
// plus a skid entry, with redirect flushing and stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        valid_n;
  logic [31:0] instr_n, pc_out_n;
  logic        consume, free;
  logic [31:0] target;

  assign consume = valid_out && !stall;
  assign free    = !valid_out || consume;
  assign target  = {redirect_pc[31:2], 2'b00};

  assign imem_read    = (state != HOLD);
  assign imem_address = (state == DISCARD) ? req_addr : pc;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    valid_n      = valid_out;
    instr_n      = instr_out;
    pc_out_n     = pc_out;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          if (!imem_resp) begin
            req_addr_n = pc;
            state_n    = DISCARD;
          end
        end else if (imem_resp) begin
          pc_n = pc + 32'd4;
          if (free) begin
            valid_n  = 1'b1;
            instr_n  = imem_rdata;
            pc_out_n = pc;
          end else begin
            skid_instr_n = imem_rdata;
            skid_pc_n    = pc;
            state_n      = HOLD;
          end
        end else if (consume) begin
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (consume) begin
          instr_n  = skid_instr;
          pc_out_n = skid_pc;
          state_n  = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
        end else if (imem_resp) begin
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      valid_out  <= 1'b0;
      instr_out  <= 32'd0;
      pc_out     <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      valid_out  <= valid_n;
      instr_out  <= instr_n;
      pc_out     <= pc_out_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, buffering, skid, redirect,
// discard of stale responses and pc wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h00000060)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_read(imem_read),
    .imem_address(imem_address),
    .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .valid_out(valid_out),
    .instr_out(instr_out),
    .pc_out(pc_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    imem_rdata = 32'd0;
    imem_resp = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_read", {31'd0, imem_read}, 32'd1);
    chk("rst_addr", imem_address, 32'h60);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pcout", pc_out, 32'd0);

    // first fetch, response on the 3rd cycle
    step();
    step();
    chk("wait_addr", imem_address, 32'h60);
    imem_resp = 1'b1;
    imem_rdata = 32'h00000013;
    step();
    imem_resp = 1'b0;
    chk("f1_valid", {31'd0, valid_out}, 32'd1);
    chk("f1_instr", instr_out, 32'h00000013);
    chk("f1_pcout", pc_out, 32'h60);
    chk("f1_addr", imem_address, 32'h64);

    // stall with two responses -> skid
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b1;
    imem_resp = 1'b1;
    imem_rdata = 32'hAAAA0001;
    step();
    chk("a_instr", instr_out, 32'hAAAA0001);
    chk("a_addr", imem_address, 32'h64);
    imem_rdata = 32'hBBBB0002;
    step();
    imem_resp = 1'b0;
    chk("hold_read", {31'd0, imem_read}, 32'd0);
    chk("hold_instr", instr_out, 32'hAAAA0001);
    step();
    chk("hold2_read", {31'd0, imem_read}, 32'd0);
    chk("hold2_pcout", pc_out, 32'h60);
    stall = 1'b0;
    step();
    chk("b_instr", instr_out, 32'hBBBB0002);
    chk("b_pcout", pc_out, 32'h64);
    chk("b_valid", {31'd0, valid_out}, 32'd1);
    chk("b_read", {31'd0, imem_read}, 32'd1);
    chk("b_addr", imem_address, 32'h68);
    step();
    chk("drain_valid", {31'd0, valid_out}, 32'd0);

    // redirect with request to 0x68 outstanding
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("disc_addr", imem_address, 32'h68);
    chk("disc_read", {31'd0, imem_read}, 32'd1);
    chk("disc_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("disc2_addr", imem_address, 32'h68);
    imem_resp = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_resp = 1'b0;
    chk("post_disc_addr", imem_address, 32'h100);
    chk("post_disc_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("stale_instr", instr_out, 32'hBBBB0002);
    chk("stale_valid", {31'd0, valid_out}, 32'd0);

    // redirect coincident with response
    imem_resp = 1'b1;
    imem_rdata = 32'hCAFEF00D;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    imem_resp = 1'b0;
    chk("rr_valid", {31'd0, valid_out}, 32'd0);
    chk("rr_addr", imem_address, 32'h200);
    chk("rr_read", {31'd0, imem_read}, 32'd1);
    imem_resp = 1'b1;
    imem_rdata = 32'h11111111;
    step();
    imem_resp = 1'b0;
    chk("t_instr", instr_out, 32'h11111111);
    chk("t_pcout", pc_out, 32'h200);
    chk("t_addr", imem_address, 32'h204);

    // reset while in HOLD
    stall = 1'b1;
    imem_resp = 1'b1;
    imem_rdata = 32'h22222222;
    step();
    imem_resp = 1'b0;
    chk("h_read", {31'd0, imem_read}, 32'd0);
    chk("h_valid", {31'd0, valid_out}, 32'd1);
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h400;
    step();
    rst = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    chk("hr_valid", {31'd0, valid_out}, 32'd0);
    chk("hr_read", {31'd0, imem_read}, 32'd1);
    chk("hr_addr", imem_address, 32'h60);
    chk("hr_instr", instr_out, 32'd0);

    // pc wrap-around
    imem_resp = 1'b1;
    imem_rdata = 32'h0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFF;
    step();
    redirect = 1'b0;
    chk("w_addr", imem_address, 32'hFFFFFFFC);
    imem_rdata = 32'h33333333;
    step();
    imem_resp = 1'b0;
    chk("w_pcout", pc_out, 32'hFFFFFFFC);
    chk("w_instr", instr_out, 32'h33333333);
    chk("w_next", imem_address, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
